mc_main_fsm: RTL and testbench
==============================

Name: mc_main_fsm

Overview:
Main control state machine for the multicycle RISC-V core. It sits directly upstream of the ALU decoder. From the instruction opcode it sequences the datapath enables and muxes, and it generates the 2-bit ALUOp that the ALU decoder consumes. It also produces ImmSrc for the immediate extender, a retired-instruction counter and debug taps. Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.

Parameters:
CNT_W, 32, width of the retired-instruction counter instret.

Ports:
clk  input  1  core clock; all state changes on its rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising clk
op  input  7  opcode field of the instruction register (Instr[6:0])
zero  input  1  ALU zero flag
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address mux: 0 = PC, 1 = ALUOut
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register / OldPC enable
ResultSrc  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  output  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = RD1
ALUSrcB  output  2  ALU B mux: 00 = RD2, 01 = ImmExt, 10 = constant 4
ALUOp  output  2  to ALU decoder: 00 = add, 01 = sub, 10 = decode funct
ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
RegWrite  output  1  register file write enable
illegal  output  1  sticky flag: an unsupported opcode was decoded
instret  output  CNT_W  count of completed legal instructions
state_DBG  output  4  current state encoding

Behaviour:
- Moore FSM; 4-bit state register. Encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
  - EXECUTER = 6, EXECUTEI = 7, ALUWB = 8, BEQ = 9, JAL = 10
- Reset (reset_n = 0 at a rising edge): state <= FETCH, illegal <= 0, instret <= 0. Reset has priority over every other event and aborts any instruction mid-sequence; no partial writes follow.
- Output defaults: every control output is 0 unless listed for the current state.
  - FETCH: IRWrite = 1, PCUpdate = 1, ALUSrcB = 10, ResultSrc = 10.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01 (branch/jump target).
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01.
  - MEMREAD: AdrSrc = 1.
  - MEMWB: ResultSrc = 01, RegWrite = 1.
  - MEMWRITE: AdrSrc = 1, MemWrite = 1.
  - EXECUTER: ALUSrcA = 10, ALUOp = 10.
  - EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10.
  - ALUWB: RegWrite = 1.
  - BEQ: ALUSrcA = 10, ALUOp = 01, Branch = 1.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, PCUpdate = 1.
- PCUpdate and Branch are internal. PCWrite = PCUpdate | (Branch & zero), combinational.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other op -> FETCH, and illegal <= 1
  - MEMADR: op = 0000011 -> MEMREAD; otherwise -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER / EXECUTEI -> ALUWB -> FETCH.
  - JAL -> ALUWB.
  - BEQ -> FETCH.
  - Encodings 11-15 are unreachable; next state is FETCH and no outputs are asserted.
- Latency in cycles, FETCH inclusive: lw 5, sw 4, R 4, I 4, jal 4, beq 3. An illegal opcode costs 2 cycles (FETCH, DECODE).
- instret increments by 1 on the clock edge that leaves MEMWB, MEMWRITE, ALUWB or BEQ. beq counts whether taken or not. It wraps modulo 2^CNT_W; illegal opcodes do not count.
- illegal stays set until reset; the FSM keeps running after an illegal opcode.
- ImmSrc is combinational from op in every state:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - any other op -> 00
- op is used only in DECODE and MEMADR; it is stable because IRWrite is 0 outside FETCH. zero is used only in BEQ.
- state_DBG = current state register.

Test Plan:
- reset_n = 0 for 2 cycles while op = 0110011 -> state_DBG = 0, IRWrite = 1, PCWrite = 1, ALUOp = 00, instret = 0, illegal = 0.
- lw, op = 0000011 -> state_DBG sequence 0,1,2,3,4,0; RegWrite = 1 only in state 4 with ResultSrc = 01; instret increments to 1 after state 4; ImmSrc = 00.
- R-type (op = 0110011) then I-type (op = 0010011) -> states 0,1,6,8,0,1,7,8,0; ALUOp = 10 in states 6 and 7; ALUSrcB = 00 in 6 and 01 in 7; instret = 2.
- beq, op = 1100011: zero = 1 in BEQ -> PCWrite = 1, ALUOp = 01; repeat with zero = 0 -> PCWrite = 0. Both paths: 3 cycles, instret increments each time, ImmSrc = 10.
- sw (op = 0100011) then jal (op = 1101111) -> states 0,1,2,5,0,1,10,8,0; MemWrite = 1 only in state 5; PCWrite = 1 in state 10; ImmSrc = 01 then 11.
- op = 1111111 -> states 0,1,0; illegal = 1 and stays set; instret unchanged. Assert reset_n = 0 during state 3 of a lw -> next state is 0 with no RegWrite pulse, and illegal, instret = 0.

Source files
------------

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle RISC-V core: sequences datapath enables and muxes,
// produces ALUOp for the ALU decoder, ImmSrc for the extender, and a retired-instruction count.
module mc_main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       op,
    input  logic             zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_DBG
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regwrite;
    } ctrl_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam int NUM_LEGAL = 6;
    localparam logic [NUM_LEGAL*7-1:0] LEGAL_OPS =
        {OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ};

    state_t           state_reg;
    state_t           state_next;
    ctrl_t            ctrl_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] instret_reg;
    logic [NUM_LEGAL-1:0] legal_hit;
    logic             op_legal;
    logic             illegal_next;
    logic             retire;

    // One comparator per supported opcode; any hit makes the opcode legal.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEGAL; gi++) begin : g_legal
            assign legal_hit[gi] = (op == LEGAL_OPS[gi*7 +: 7]);
        end
    endgenerate

    assign op_legal = |legal_hit;

    // Moore control word for a given state; anything not listed stays 0.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite   = 1'b1;
                c.pcupdate  = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            S_DECODE: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b01;
            end
            S_MEMADR: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
            end
            S_MEMREAD: begin
                c.adrsrc = 1'b1;
            end
            S_MEMWB: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTER: begin
                c.alusrca = 2'b10;
                c.aluop   = 2'b10;
            end
            S_EXECUTEI: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
                c.aluop   = 2'b10;
            end
            S_ALUWB: begin
                c.regwrite = 1'b1;
            end
            S_BEQ: begin
                c.alusrca = 2'b10;
                c.aluop   = 2'b01;
                c.branch  = 1'b1;
            end
            S_JAL: begin
                c.alusrca  = 2'b01;
                c.alusrcb  = 2'b10;
                c.pcupdate = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_for(input state_t s, input logic [6:0] opc);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH: n = S_DECODE;
            S_DECODE: begin
                case (opc)
                    OP_LW, OP_SW: n = S_MEMADR;
                    OP_RTYPE:     n = S_EXECUTER;
                    OP_ITYPE:     n = S_EXECUTEI;
                    OP_JAL:       n = S_JAL;
                    OP_BEQ:       n = S_BEQ;
                    default:      n = S_FETCH;
                endcase
            end
            S_MEMADR:   n = (opc == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  n = S_MEMWB;
            S_MEMWB:    n = S_FETCH;
            S_MEMWRITE: n = S_FETCH;
            S_EXECUTER: n = S_ALUWB;
            S_EXECUTEI: n = S_ALUWB;
            S_ALUWB:    n = S_FETCH;
            S_BEQ:      n = S_FETCH;
            S_JAL:      n = S_ALUWB;
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

    always_comb begin
        state_next   = next_for(state_reg, op);
        illegal_next = (state_reg == S_DECODE) && !op_legal;
        retire       = 1'b0;
        case (state_reg)
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: retire = 1'b1;
            default:                             retire = 1'b0;
        endcase
    end

    // Outputs are registered from the next state so they always match state_reg.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= S_FETCH;
            ctrl_reg    <= ctrl_for(S_FETCH);
            illegal_reg <= 1'b0;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_for(state_next);
            if (illegal_next) begin
                illegal_reg <= 1'b1;
            end
            if (retire) begin
                instret_reg <= instret_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite   = ctrl_reg.pcupdate | (ctrl_reg.branch & zero);
    assign AdrSrc    = ctrl_reg.adrsrc;
    assign MemWrite  = ctrl_reg.memwrite;
    assign IRWrite   = ctrl_reg.irwrite;
    assign ResultSrc = ctrl_reg.resultsrc;
    assign ALUSrcA   = ctrl_reg.alusrca;
    assign ALUSrcB   = ctrl_reg.alusrcb;
    assign ALUOp     = ctrl_reg.aluop;
    assign RegWrite  = ctrl_reg.regwrite;
    assign illegal   = illegal_reg;
    assign instret   = instret_reg;
    assign state_DBG = state_reg;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Scoreboard bench for mc_main_fsm: directed opcode sequences push expected per-cycle
// outputs into a queue that a separate monitor pops and compares every cycle.
module tb_mc_main_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic        clk;
    logic        reset_n;
    logic [6:0]  op;
    logic        zero;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [31:0] instret;
    logic [3:0]  state_DBG;

    typedef struct {
        logic [3:0]  st;
        logic [14:0] ctrl;
        logic [31:0] ir;
        logic        il;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    mc_main_fsm #(.CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal), .instret(instret),
        .state_DBG(state_DBG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs straight from the state table; packed as
    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite}.
    function automatic logic [14:0] exp_ctrl(input logic [3:0] st, input logic z,
                                             input logic [6:0] opc);
        logic pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, ao, imm;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
        rs = 0; sa = 0; sb = 0; ao = 0; imm = 0;
        case (st)
            4'd0:  begin irw = 1; pcw = 1; sb = 2'b10; rs = 2'b10; end
            4'd1:  begin sa = 2'b01; sb = 2'b01; end
            4'd2:  begin sa = 2'b10; sb = 2'b01; end
            4'd3:  adr = 1;
            4'd4:  begin rs = 2'b01; rw = 1; end
            4'd5:  begin adr = 1; mw = 1; end
            4'd6:  begin sa = 2'b10; ao = 2'b10; end
            4'd7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            4'd8:  rw = 1;
            4'd9:  begin sa = 2'b10; ao = 2'b01; pcw = z; end
            4'd10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (opc == SW)      imm = 2'b01;
        else if (opc == BQ) imm = 2'b10;
        else if (opc == JL) imm = 2'b11;
        return {pcw, adr, mw, irw, rs, sa, sb, ao, imm, rw};
    endfunction

    // One cycle: apply inputs after the falling edge and queue what the DUT must show now.
    task automatic step(input logic rst, input logic [6:0] opc, input logic z,
                        input logic chk, input logic [3:0] st,
                        input logic [31:0] ir, input logic il);
        exp_t e;
        @(negedge clk);
        reset_n = rst;
        op      = opc;
        zero    = z;
        if (chk) begin
            e.st   = st;
            e.ctrl = exp_ctrl(st, z, opc);
            e.ir   = ir;
            e.il   = il;
            q.push_back(e);
        end
    endtask

    // Monitor: every cycle the DUT presents a state; compare against the oldest expectation.
    initial begin
        exp_t e;
        logic [14:0] act;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() != 0) begin
                e   = q.pop_front();
                act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                       ALUOp, ImmSrc, RegWrite};
                checks++;
                if (state_DBG !== e.st) begin
                    errors++;
                    $display("FAIL state: got %0d want %0d", state_DBG, e.st);
                end
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl st=%0d: got %015b want %015b", e.st, act, e.ctrl);
                end
                checks++;
                if (instret !== e.ir) begin
                    errors++;
                    $display("FAIL instret st=%0d: got %0d want %0d", e.st, instret, e.ir);
                end
                checks++;
                if (illegal !== e.il) begin
                    errors++;
                    $display("FAIL illegal st=%0d: got %0b want %0b", e.st, illegal, e.il);
                end
                $display("check st=%0d ctrl=%015b instret=%0d illegal=%0b",
                         state_DBG, act, instret, illegal);
            end
        end
    end

    initial begin
        int waited;
        reset_n = 1'b0;
        op      = RT;
        zero    = 1'b0;
        // reset held two cycles
        step(0, RT, 0, 0, 0, 0, 0);
        step(0, RT, 0, 1, 0, 0, 0);
        // lw: 0,1,2,3,4
        step(1, LW, 0, 1, 0, 0, 0);
        step(1, LW, 0, 1, 1, 0, 0);
        step(1, LW, 0, 1, 2, 0, 0);
        step(1, LW, 0, 1, 3, 0, 0);
        step(1, LW, 0, 1, 4, 0, 0);
        // R-type with zero high to show zero is ignored outside BEQ
        step(1, RT, 1, 1, 0, 1, 0);
        step(1, RT, 1, 1, 1, 1, 0);
        step(1, RT, 1, 1, 6, 1, 0);
        step(1, RT, 1, 1, 8, 1, 0);
        // I-type
        step(1, IT, 0, 1, 0, 2, 0);
        step(1, IT, 0, 1, 1, 2, 0);
        step(1, IT, 0, 1, 7, 2, 0);
        step(1, IT, 0, 1, 8, 2, 0);
        // beq taken, then not taken
        step(1, BQ, 1, 1, 0, 3, 0);
        step(1, BQ, 1, 1, 1, 3, 0);
        step(1, BQ, 1, 1, 9, 3, 0);
        step(1, BQ, 0, 1, 0, 4, 0);
        step(1, BQ, 0, 1, 1, 4, 0);
        step(1, BQ, 0, 1, 9, 4, 0);
        // sw
        step(1, SW, 0, 1, 0, 5, 0);
        step(1, SW, 0, 1, 1, 5, 0);
        step(1, SW, 0, 1, 2, 5, 0);
        step(1, SW, 0, 1, 5, 5, 0);
        // jal
        step(1, JL, 0, 1, 0, 6, 0);
        step(1, JL, 0, 1, 1, 6, 0);
        step(1, JL, 0, 1, 10, 6, 0);
        step(1, JL, 0, 1, 8, 6, 0);
        // illegal opcode: FETCH, DECODE, back to FETCH with sticky flag
        step(1, BAD, 0, 1, 0, 7, 0);
        step(1, BAD, 0, 1, 1, 7, 0);
        // lw aborted by reset in MEMREAD
        step(1, LW, 0, 1, 0, 7, 1);
        step(1, LW, 0, 1, 1, 7, 1);
        step(1, LW, 0, 1, 2, 7, 1);
        step(0, LW, 0, 1, 3, 7, 1);
        step(1, LW, 0, 1, 0, 0, 0);
        step(1, LW, 0, 1, 1, 0, 0);
        step(1, LW, 0, 1, 2, 0, 0);

        waited = 0;
        while (q.size() != 0 && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
